// File: rtl/sr_recovery_pipe.sv
// Two-stage rotation-recovery pipe: majority-voted delta, cyclic rotate, anchor XOR and lock FSM.
// Latency 1 edge from S1 capture to s_rec; valid/ready backpressure, at most 2 beats buffered.
module sr_recovery_pipe #(
  parameter int DATA_W   = 512,
  parameter int DELTA_W  = $clog2(DATA_W),
  parameter int TAP1     = 157,
  parameter int TAP2     = 311,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2,
  parameter logic [DATA_W-1:0] KA_ANCHOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  m_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  s_rec,
  output logic [DELTA_W-1:0] out_delta,
  output logic               locked,
  input  logic               anchor_we,
  input  logic [DATA_W-1:0]  anchor_in
);

  typedef enum logic {ACQUIRE, LOCKED} state_t;

  localparam logic [DELTA_W:0] DW_L = (DELTA_W+1)'(DATA_W);

  logic               s1_valid;
  logic [DATA_W-1:0]  s1_d;
  logic [DELTA_W-1:0] delta_reg;
  logic [DATA_W-1:0]  anchor_reg;
  state_t             state, state_nx;
  logic [3:0]         cnt, cnt_nx, cnt_inc;

  logic advance, transfer, accept;
  assign advance  = !out_valid || out_ready;
  assign transfer = s1_valid && advance;
  assign in_ready = !s1_valid || transfer;
  assign accept   = in_valid && in_ready;

  logic [DELTA_W-1:0] v1, v2, v3, raw, vote;
  logic [DELTA_W:0]   raw_sub;
  logic               unanimous;
  assign v1        = s1_d[DELTA_W-1:0];
  assign v2        = s1_d[TAP1 +: DELTA_W];
  assign v3        = s1_d[TAP2 +: DELTA_W];
  assign raw       = (v1 & v2) | (v2 & v3) | (v3 & v1);
  assign raw_sub   = {1'b0, raw} - DW_L;
  assign vote      = ({1'b0, raw} >= DW_L) ? raw_sub[DELTA_W-1:0] : raw;
  assign unanimous = (v1 == v2) && (v2 == v3);

  // Log-depth barrel rotate; each stage rotates by a fixed 2^k so no shift ever exceeds the word.
  logic [DELTA_W:0][DATA_W-1:0] rstage;
  assign rstage[0] = s1_d;
  for (genvar k = 0; k < DELTA_W; k++) begin : g_ror
    localparam int SH = (1 << k) % DATA_W;
    if (SH == 0) begin : g_id
      assign rstage[k+1] = rstage[k];
    end else begin : g_rot
      assign rstage[k+1] = delta_reg[k] ? {rstage[k][SH-1:0], rstage[k][DATA_W-1:SH]}
                                        : rstage[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_d     <= m_in;
    end else if (transfer) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s_rec     <= '0;
      out_delta <= '0;
      delta_reg <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      s_rec     <= rstage[DELTA_W] ^ anchor_reg;
      out_delta <= delta_reg;
      delta_reg <= vote;
    end else if (advance) begin
      out_valid <= 1'b0;
    end
  end

  // A transfer on the load edge still sees the old anchor through the non-blocking update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anchor_reg <= KA_ANCHOR;
    end else if (anchor_we) begin
      anchor_reg <= anchor_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACQUIRE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cnt_inc  = cnt + 4'd1;
    if (transfer) begin
      case (state)
        ACQUIRE: begin
          if (!unanimous) begin
            cnt_nx = '0;
          end else if (cnt_inc == 4'(LOCK_CNT)) begin
            state_nx = LOCKED;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        LOCKED: begin
          if (unanimous) begin
            cnt_nx = '0;
          end else if (cnt_inc == 4'(LOSS_CNT)) begin
            state_nx = ACQUIRE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        default: begin
          state_nx = ACQUIRE;
          cnt_nx   = '0;
        end
      endcase
    end
    // Anchor reload invalidates any lock history.
    if (anchor_we) begin
      state_nx = ACQUIRE;
      cnt_nx   = '0;
    end
  end

  assign locked = (state == LOCKED);

endmodule
